button_event_arbiter: RTL and testbench

- Sits between a bank of debouncers and the downstream counter/display logic.
- Classifies each completed press as short or long by hold time.
- Queues one pending event per button and shares a single event output among the buttons using round-robin arbitration.
- Output is a valid/ready handshake, so the consumer may stall.

---
 rtl/button_event_arbiter_if.sv | 34 +++
 rtl/button_event_arbiter.sv | 173 +++++++++++++++++
 tb/tb_button_event_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button arbiter and its consumer.
//   evt_valid : an event is presented on evt_id / evt_long
//   evt_ready : consumer accepts the presented event this cycle
//   evt_id    : index of the button the event belongs to
//   evt_long  : 1 = long press, 0 = short press
//   evt_drop  : sticky per-button flag, a release event was lost
// master = arbiter side, slave = consumer side.
interface button_event_arbiter_if #(
  parameter int NUM_BTNS = 4
);
  localparam int ID_W = $clog2(NUM_BTNS);

  logic                evt_valid;
  logic                evt_ready;
  logic [ID_W-1:0]     evt_id;
  logic                evt_long;
  logic [NUM_BTNS-1:0] evt_drop;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_long,
    output evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_long,
    input  evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Button event arbiter.
// Times each debounced press, classifies it as short or long on release,
// keeps one pending event per button and hands the events out one at a
// time through a valid/ready slot, choosing among pending buttons in
// round-robin order.
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : asynchronous active-high, clears all state
//   btn_level : debounced button levels (1 = pressed), synchronous to clk
//   evt       : event handshake (valid/ready/id/long/drop), master side
module button_event_arbiter #(
  parameter int NUM_BTNS    = 4,
  parameter int LONG_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTNS-1:0]  btn_level,
  button_event_arbiter_if.master evt
);

  localparam int ID_W  = $clog2(NUM_BTNS);
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_BTNS - 1);

  logic [NUM_BTNS-1:0] release_w;    // release edge sampled this cycle
  logic [NUM_BTNS-1:0] rel_long_w;   // hold length of that release is long

  logic [NUM_BTNS-1:0] pending_reg;
  logic [NUM_BTNS-1:0] pend_long_reg;
  logic [NUM_BTNS-1:0] drop_reg;
  logic [ID_W-1:0]     rr_ptr_reg;

  logic                valid_reg;
  logic [ID_W-1:0]     id_reg;
  logic                long_reg;

  // ---------------------------------------------------------------------
  // Per-button hold timer. btn_prev_reg doubles as the IDLE/HELD state.
  // The counter equals the number of consecutive edges that sampled 1,
  // saturating at LONG_CYCLES so the long test is a single compare.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      logic [0:0]       btn_prev_reg;
      logic [CNT_W-1:0] hold_cnt_reg;

      assign release_w[gi]  = (btn_prev_reg == ST_HELD) && !btn_level[gi];
      assign rel_long_w[gi] = (hold_cnt_reg >= CNT_MAX);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          btn_prev_reg <= ST_IDLE;
          hold_cnt_reg <= '0;
        end else begin
          case (btn_prev_reg)
            ST_IDLE: begin
              if (btn_level[gi]) begin
                btn_prev_reg <= ST_HELD;
                hold_cnt_reg <= CNT_W'(1);
              end
            end
            default: begin
              if (btn_level[gi]) begin
                if (hold_cnt_reg != CNT_MAX) begin
                  hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                end
              end else begin
                btn_prev_reg <= ST_IDLE;
                hold_cnt_reg <= '0;
              end
            end
          endcase
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin grant: first pending index at or after rr_ptr, wrapping.
  // The slot is free when empty or being consumed this cycle, which lets
  // a new event load on the same edge the old one is accepted.
  // ---------------------------------------------------------------------
  logic                slot_free_w;
  logic                grant_vld_w;
  logic [ID_W-1:0]     grant_idx_w;
  logic [NUM_BTNS-1:0] grant_oh_w;

  assign slot_free_w = !valid_reg || evt.evt_ready;

  always_comb begin
    int idx;
    idx         = 0;
    grant_vld_w = 1'b0;
    grant_idx_w = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_BTNS) begin
        idx = idx - NUM_BTNS;
      end
      if (!grant_vld_w && pending_reg[idx]) begin
        grant_vld_w = 1'b1;
        grant_idx_w = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_oh_w = '0;
    if (grant_vld_w && slot_free_w) begin
      grant_oh_w[grant_idx_w] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pending store. A release while the button's previous event is still
  // waiting (and not leaving this edge) is lost and flagged; a release on
  // the same edge the old event is granted simply replaces it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg   <= '0;
      pend_long_reg <= '0;
      drop_reg      <= '0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (release_w[i]) begin
          if (pending_reg[i] && !grant_oh_w[i]) begin
            drop_reg[i] <= 1'b1;
          end else begin
            pending_reg[i]   <= 1'b1;
            pend_long_reg[i] <= rel_long_w[i];
          end
        end else if (grant_oh_w[i]) begin
          pending_reg[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output slot. id/long only change when the slot reloads, so they stay
  // stable while the consumer stalls.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      id_reg     <= '0;
      long_reg   <= 1'b0;
      rr_ptr_reg <= '0;
    end else if (slot_free_w) begin
      if (grant_vld_w) begin
        valid_reg  <= 1'b1;
        id_reg     <= grant_idx_w;
        long_reg   <= pend_long_reg[grant_idx_w];
        rr_ptr_reg <= (grant_idx_w == LAST_IDX) ? '0 : grant_idx_w + ID_W'(1);
      end else begin
        valid_reg  <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = valid_reg;
  assign evt.evt_id    = id_reg;
  assign evt.evt_long  = long_reg;
  assign evt.evt_drop  = drop_reg;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (NUM_BTNS=4, LONG_CYCLES=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_button_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] btn_level;

  int tests;
  int fails;

  button_event_arbiter_if #(.NUM_BTNS(4)) evt_if ();

  button_event_arbiter #(
    .NUM_BTNS    (4),
    .LONG_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_level (btn_level),
    .evt       (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input int id, input logic lng);
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
    chk({tag, "_id"},    32'(evt_if.evt_id),    32'(id));
    chk({tag, "_long"},  32'(evt_if.evt_long),  32'(lng));
  endtask

  // Hold button b for exactly h sampled edges, then drive it low.
  task automatic press(input int b, input int h);
    btn_level[b] = 1'b1;
    repeat (h) step();
    btn_level[b] = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    btn_level = '0;
    evt_if.evt_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_id",    32'(evt_if.evt_id),    32'd0);
    chk("rst_long",  32'(evt_if.evt_long),  32'd0);
    chk("rst_drop",  32'(evt_if.evt_drop),  32'd0);
    reset = 1'b0;
    step();

    // Short/long threshold and saturation on button 0.
    press(0, 7);
    step();
    chk("h7_lat1", 32'(evt_if.evt_valid), 32'd0);
    step();
    expect_evt("h7", 0, 1'b0);
    step();
    chk("h7_done", 32'(evt_if.evt_valid), 32'd0);

    press(0, 8);
    step();
    step();
    expect_evt("h8", 0, 1'b1);
    step();
    chk("h8_done", 32'(evt_if.evt_valid), 32'd0);

    press(0, 30);
    step();
    step();
    expect_evt("h30", 0, 1'b1);
    step();
    chk("h30_done", 32'(evt_if.evt_valid), 32'd0);

    // Stall: event held stable while evt_ready=0.
    evt_if.evt_ready = 1'b0;
    press(2, 3);
    step();
    step();
    expect_evt("stall0", 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_evt("stall_hold", 2, 1'b0);
    end
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    chk("stall_taken", 32'(evt_if.evt_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_once", 32'(evt_if.evt_valid), 32'd0);
    end

    // Button 3 alone brings rr_ptr back to 0.
    evt_if.evt_ready = 1'b1;
    press(3, 2);
    step();
    step();
    expect_evt("b3", 3, 1'b0);
    step();
    chk("b3_done", 32'(evt_if.evt_valid), 32'd0);

    // Simultaneous release of 0,1,3 with rr_ptr=0.
    btn_level = 4'b1011;
    step();
    step();
    btn_level = 4'b0000;
    step();
    step();
    expect_evt("rr013_a", 0, 1'b0);
    step();
    expect_evt("rr013_b", 1, 1'b0);
    step();
    expect_evt("rr013_c", 3, 1'b0);
    step();
    chk("rr013_done", 32'(evt_if.evt_valid), 32'd0);

    // rr_ptr back at 0: release of 0 and 3 gives 0 then 3.
    btn_level = 4'b1001;
    step();
    step();
    btn_level = 4'b0000;
    step();
    step();
    expect_evt("rr03_a", 0, 1'b0);
    step();
    expect_evt("rr03_b", 3, 1'b0);
    step();
    chk("rr03_done", 32'(evt_if.evt_valid), 32'd0);

    // Button 1 alone sets rr_ptr=2, then 1 and 3 together wrap: 3, 1.
    press(1, 2);
    step();
    step();
    expect_evt("b1", 1, 1'b0);
    step();
    chk("b1_done", 32'(evt_if.evt_valid), 32'd0);
    btn_level = 4'b1010;
    step();
    step();
    btn_level = 4'b0000;
    step();
    step();
    expect_evt("wrap_a", 3, 1'b0);
    step();
    expect_evt("wrap_b", 1, 1'b0);
    step();
    chk("wrap_done", 32'(evt_if.evt_valid), 32'd0);

    // Drop: slot holds a short, pending holds a short, a long is lost.
    evt_if.evt_ready = 1'b0;
    press(1, 2);
    step();
    step();
    expect_evt("drop_slot", 1, 1'b0);
    press(1, 2);
    step();
    chk("drop_none_yet", 32'(evt_if.evt_drop), 32'h0);
    press(1, 9);
    step();
    chk("drop_set", 32'(evt_if.evt_drop), 32'h2);
    expect_evt("drop_hold", 1, 1'b0);
    evt_if.evt_ready = 1'b1;
    step();
    expect_evt("drop_kept", 1, 1'b0);
    step();
    chk("drop_empty", 32'(evt_if.evt_valid), 32'd0);
    evt_if.evt_ready = 1'b0;
    step();
    chk("drop_sticky", 32'(evt_if.evt_drop), 32'h2);
    chk("drop_none", 32'(evt_if.evt_valid), 32'd0);

    // Reset mid-operation with an event presented and another pending;
    // button 3 is held through reset and timed from the first new edge.
    btn_level = 4'b1101;
    step();
    step();
    btn_level = 4'b1000;
    step();
    step();
    expect_evt("pre_rst", 2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("arst_id",    32'(evt_if.evt_id),    32'd0);
    chk("arst_long",  32'(evt_if.evt_long),  32'd0);
    chk("arst_drop",  32'(evt_if.evt_drop),  32'd0);
    step();
    reset = 1'b0;
    evt_if.evt_ready = 1'b1;
    repeat (7) step();
    btn_level[3] = 1'b0;
    step();
    chk("post_rst_no_stale", 32'(evt_if.evt_valid), 32'd0);
    step();
    expect_evt("post_rst_b3", 3, 1'b0);
    step();
    chk("post_rst_done", 32'(evt_if.evt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
